// File: rtl/irq_sequencer.sv
// Interrupt entry sequencer: waits for a safe MEM-stage point, then issues a one-cycle flush/CSR-trap pulse.
// Optional vectored trap targets when compiled with IRQ_VECTORED_EN (mtvec mode 2'b01).
module irq_sequencer #(
  parameter int XLEN          = 32,
  parameter int CAUSE_W       = 5,
  parameter int WAIT_LIMIT    = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               irq_pending,
  input  logic               mie_global,
  input  logic [CAUSE_W-1:0] irq_cause,
  input  logic               mret_type,
  input  logic               branch_hazard,
  input  logic               stall_pipl,
  input  logic               mem_valid,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic [XLEN-1:0]    mtvec,
  output logic               interrupt,
  output logic               trap_pc_sel,
  output logic [XLEN-1:0]    trap_pc,
  output logic               mepc_we,
  output logic [XLEN-1:0]    mepc_wdata,
  output logic               mcause_we,
  output logic [XLEN-1:0]    mcause_wdata,
  output logic               mstatus_trap,
  output logic               busy,
  output logic               irq_starved
);

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, TAKE, SETTLE} state_t;

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_MAX    = WCW'(WAIT_LIMIT);
  localparam logic [WCW-1:0] WAIT_LAST   = WCW'(WAIT_LIMIT - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  state_t          state, next_state;
  logic [WCW-1:0]  wait_cnt;
  logic [SCW-1:0]  settle_cnt;
  logic [XLEN-1:0] mepc_q, mcause_q, trap_pc_q;
  logic            starved_q;
  logic            irq_req, safe, capture, waiting;
  logic [XLEN-1:0] trap_base, trap_target;

  assign irq_req = irq_pending & mie_global;
  // mret in flight makes the point unsafe, so mret wins over a pending interrupt.
  assign safe    = mem_valid & ~stall_pipl & ~branch_hazard & ~mret_type;
  assign capture = (state == WAIT_SAFE) & irq_req & safe;
  assign waiting = (state == WAIT_SAFE) & irq_req & ~safe;

  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef IRQ_VECTORED_EN
  always_comb begin
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01)
      trap_target = trap_base + (XLEN'(irq_cause) << 2);
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign trap_target       = trap_base;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (irq_req) next_state = WAIT_SAFE;
      WAIT_SAFE: begin
        if (!irq_req)  next_state = IDLE;
        else if (safe) next_state = TAKE;
      end
      TAKE:      next_state = SETTLE;
      SETTLE:    if (settle_cnt == SETTLE_LAST) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Wait counter only runs while held off; any other cycle clears it so each entry starts at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      starved_q <= 1'b0;
    end else if (waiting) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WCW'(1);
      if (wait_cnt == WAIT_LAST) starved_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              settle_cnt <= '0;
    else if (state == SETTLE)  settle_cnt <= settle_cnt + SCW'(1);
    else                       settle_cnt <= '0;
  end

  // Trap data is registered at the safe point and held until the next capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mepc_q    <= '0;
      mcause_q  <= '0;
      trap_pc_q <= '0;
    end else if (capture) begin
      mepc_q    <= mem_pc;
      mcause_q  <= {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, irq_cause};
      trap_pc_q <= trap_target;
    end
  end

  assign interrupt    = (state == TAKE);
  assign trap_pc_sel  = (state == TAKE);
  assign mepc_we      = (state == TAKE);
  assign mcause_we    = (state == TAKE);
  assign mstatus_trap = (state == TAKE);
  assign busy         = (state != IDLE);
  assign irq_starved  = starved_q;
  assign trap_pc      = trap_pc_q;
  assign mepc_wdata   = mepc_q;
  assign mcause_wdata = mcause_q;

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Sequences asynchronous interrupt entry into the 5-stage core pipeline.
- Waits for a safe point, then issues the single-cycle `interrupt` flush pulse consumed by the pipeline controller.
- In the same cycle it writes mepc/mcause/mstatus-trap strobes and redirects fetch to the trap vector.
- Sits beside the CSR file; arbitrates between pending interrupts and in-flight mret/branch/stall activity.

Parameters:
- XLEN, 32, datapath/PC width
- CAUSE_W, 5, width of interrupt cause code
- WAIT_LIMIT, 64, cycles in WAIT_SAFE before starve flag sets (≥2)
- SETTLE_CYCLES, 2, post-entry holdoff cycles before new interrupt accepted (≥1)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- irq_pending  in  1  level, an enabled interrupt is pending (from CSR mip&mie)
- mie_global  in  1  mstatus.MIE
- irq_cause  in  CAUSE_W  cause code of highest-priority pending interrupt
- mret_type  in  1  mret in flight (same signal the pipeline controller sees)
- branch_hazard  in  1  taken branch/jump redirect this cycle
- stall_pipl  in  1  global pipeline stall
- mem_valid  in  1  MEM stage holds a valid, non-bubble instruction
- mem_pc  in  XLEN  PC of MEM-stage instruction
- mtvec  in  XLEN  trap vector CSR
- interrupt  out  1  flush pulse to pipeline controller
- trap_pc_sel  out  1  fetch PC mux select to trap_pc
- trap_pc  out  XLEN  redirect target
- mepc_we  out  1  mepc write strobe
- mepc_wdata  out  XLEN  value for mepc
- mcause_we  out  1  mcause write strobe
- mcause_wdata  out  XLEN  {1'b1, zero-ext irq_cause}
- mstatus_trap  out  1  CSR: MPIE<=MIE, MIE<=0
- busy  out  1  state != IDLE
- irq_starved  out  1  sticky, WAIT_LIMIT exceeded

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counters=0, captured PC/cause=0. All outputs 0, including irq_starved.
- States: IDLE, WAIT_SAFE, TAKE, SETTLE.
- IDLE -> WAIT_SAFE when irq_pending & mie_global.
- WAIT_SAFE:
  - safe = mem_valid & ~stall_pipl & ~branch_hazard & ~mret_type.
  - If (~irq_pending | ~mie_global), go to IDLE without taking the interrupt; wait counter clears.
  - Else if safe: capture mem_pc and irq_cause, go to TAKE.
  - Else: wait counter increments, saturating at WAIT_LIMIT; on reaching WAIT_LIMIT, irq_starved <= 1 (cleared only by reset).
  - mret and irq together: mret wins; stay in WAIT_SAFE.
- TAKE (exactly 1 cycle):
  - interrupt=1, trap_pc_sel=1, mepc_we=1, mcause_we=1, mstatus_trap=1.
  - mepc_wdata = captured PC; mcause_wdata MSB=1, cause in low bits.
  - trap_pc = {mtvec[XLEN-1:2],2'b00}.
  - Pulse is unconditional, even if stall_pipl rises this cycle; clear has priority in the pipeline controller.
  - Next state: SETTLE.
- SETTLE: counts SETTLE_CYCLES then goes to IDLE. irq_pending ignored so the MIE clear propagates.
- All strobes low outside TAKE. trap_pc/mepc_wdata/mcause_wdata hold the captured values while not strobed.
- Latency: from safe in WAIT_SAFE to interrupt pulse is 1 cycle. From IDLE with safe conditions already true, it is 2 cycles.
- Wait counter is reset on every entry to WAIT_SAFE.

Optional Feature:
- Macro: IRQ_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01, trap_pc = {mtvec[XLEN-1:2],2'b00} + (irq_cause<<2), computed mod 2^XLEN. Otherwise direct mode as above.
- Undefined: always direct mode; mtvec[1:0] ignored.

Test Plan:
- Reset mid-TAKE: assert reset_n=0 during TAKE -> all outputs 0 immediately; state IDLE after release.
- Basic entry: irq_pending=1, mie_global=1, cause=7, mem_valid=1, mem_pc=0x0000_0120, mtvec=0x0000_0400 -> interrupt pulses 1 cycle, 2 cycles after irq rises; mepc_wdata=0x120, mcause_wdata=0x8000_0007, trap_pc=0x400; busy low after 2 SETTLE cycles.
- Hold-off: stall_pipl=1 for 5 cycles, then branch_hazard=1 for 1 cycle, then mret_type=1 for 1 cycle -> no pulse during these cycles; pulse the cycle after all three clear with mem_valid=1.
- Withdrawal: irq_pending drops while in WAIT_SAFE -> returns to IDLE, no strobes, mepc untouched.
- Starvation: WAIT_LIMIT=4, stall_pipl held high for 10 cycles -> irq_starved=1 from the 4th wait cycle and stays 1 after entry completes.
- Vectored (IRQ_VECTORED_EN): mtvec=0x0000_0401, cause=3 -> trap_pc=0x0000_040C; same stimulus without the macro -> trap_pc=0x0000_0400.
